// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: default widths, reset PC, fetch FSM state
// encoding and the prefetch buffer entry layout {pc, instr}.
package mips_pkg;

    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    // Buffer entry: instruction tagged with the address it was fetched from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with a registered head.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, push_data write an entry (ignored when full without a pop)
//   pop             consume the head (ignored when empty)
//   flush           empty the buffer; wins over push and pop
//   count           registered entry count
//   head_valid      buffer non-empty, head_data is the oldest entry
//   head_data       oldest entry, zero while empty
module fetch_fifo #(
    parameter int unsigned DATA_W = 49,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    head_valid,
    output logic [DATA_W-1:0]       head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              head_valid_q, head_valid_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic              do_push;
    logic              do_pop;

    // Next pointers/count and the value the head register will show next cycle.
    always_comb begin
        do_pop       = pop && (count_q != '0);
        do_push      = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        rd_ptr_d     = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d     = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d      = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        head_valid_d = (count_d != '0);
        head_data_d  = '0;
        if (head_valid_d) begin
            // The new head is the entry being written this cycle when the
            // read pointer lands on the write slot (empty or draining to one).
            if (do_push && (rd_ptr_d == wr_ptr_q)) begin
                head_data_d = push_data;
            end else begin
                head_data_d = mem_q[rd_ptr_d];
            end
        end
        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
            head_data_d  = '0;
        end
    end

    // Control state and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    // Storage needs no reset; count and head gate visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count      = count_q;
    assign head_valid = head_valid_q;
    assign head_data  = head_data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues word-aligned reads to a fixed-latency-1
// instruction memory, buffers tagged responses in a prefetch FIFO and
// presents them to decode through a valid/ready handshake.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   fetch_en                     allow new requests
//   imem_req, imem_addr          memory read request / address
//   imem_rdata                   read data for last cycle's request
//   instr_valid, instr_ready     decode handshake
//   instr, instr_pc              head instruction and its address
//   redirect_valid, redirect_pc  branch/jump redirect
//   occupancy                    buffer entry count
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
    parameter int unsigned INSTR_W  = mips_pkg::INSTR_W,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = mips_pkg::RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_en,
    output logic                    imem_req,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]      imem_rdata,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [INSTR_W-1:0]      instr,
    output logic [ADDR_W-1:0]       instr_pc,
    input  logic                    redirect_valid,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic [$clog2(DEPTH):0]  occupancy
);

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned CRD_W   = CNT_W + 1;
    localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

    localparam logic [1:0] S_IDLE  = 2'(mips_pkg::IDLE);
    localparam logic [1:0] S_FETCH = 2'(mips_pkg::FETCH);
    localparam logic [1:0] S_FLUSH = 2'(mips_pkg::FLUSH);

    logic [1:0]         st_q, st_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               imem_req_q, imem_req_d;
    logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
    logic               resp_pend_q, resp_pend_d;
    logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CRD_W-1:0]   used_cnt;
    logic [CNT_W-1:0]   fifo_count;
    logic               head_valid;
    logic [ENTRY_W-1:0] head_data;

    // State, pc, request and response-tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= S_IDLE;
            pc_q        <= ADDR_W'(RESET_PC);
            imem_req_q  <= 1'b0;
            imem_addr_q <= ADDR_W'(RESET_PC);
            resp_pend_q <= 1'b0;
            resp_pc_q   <= '0;
        end else begin
            st_q        <= st_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            resp_pend_q <= resp_pend_d;
            resp_pc_q   <= resp_pc_d;
        end
    end

    // Next state and next request. A request registered now is presented
    // next cycle, so the credit counts buffered entries plus both the
    // response arriving now and the request currently on the bus.
    always_comb begin
        st_d        = st_q;
        pc_d        = pc_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        resp_pend_d = imem_req_q;
        resp_pc_d   = imem_addr_q;
        used_cnt    = CRD_W'(fifo_count) + CRD_W'(resp_pend_q) + CRD_W'(imem_req_q);

        case (st_q)
            S_IDLE:  if (fetch_en)  st_d = S_FETCH;
            S_FETCH: if (!fetch_en) st_d = S_IDLE;
            S_FLUSH: st_d = fetch_en ? S_FETCH : S_IDLE;
            default: st_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            // Squash the request on the bus; the FIFO flush drops the one arriving now.
            st_d        = S_FLUSH;
            pc_d        = redirect_pc & ~ADDR_W'(3);
            resp_pend_d = 1'b0;
        end else if ((st_d == S_FETCH) && (used_cnt < CRD_W'(DEPTH))) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
            pc_d        = pc_q + ADDR_W'(4);
        end
    end

    fetch_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fetch_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (resp_pend_q),
        .push_data  ({resp_pc_q, imem_rdata}),
        .pop        (instr_ready),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head_data  (head_data)
    );

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = head_valid;
    assign instr       = head_data[INSTR_W-1:0];
    assign instr_pc    = head_data[ENTRY_W-1 -: ADDR_W];
    assign occupancy   = fifo_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a latency-1 memory model,
// an address/instruction scoreboard and directed scenarios for streaming,
// back-pressure, redirect, pc wrap and asynchronous reset.
module tb_instruction_fetch_unit;
    import mips_pkg::*;

    localparam int unsigned AW    = 17;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_en;
    logic              imem_req;
    logic [AW-1:0]     imem_addr;
    logic [IW-1:0]     imem_rdata = '0;
    logic              instr_valid;
    logic              instr_ready;
    logic [IW-1:0]     instr;
    logic [AW-1:0]     instr_pc;
    logic              redirect_valid;
    logic [AW-1:0]     redirect_pc;
    logic [2:0]        occupancy;

    int                n_cmp = 0;
    int                n_err = 0;
    int                n_deliv = 0;
    logic [AW-1:0]     last_pc = '0;
    logic [AW-1:0]     exp_pc = '0;
    fetch_entry_t      exp_q[$];
    fetch_entry_t      mon_e;

    instruction_fetch_unit #(
        .ADDR_W   (AW),
        .INSTR_W  (IW),
        .DEPTH    (DEPTH),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // Memory contents: address 0 holds 0x8D100200, every word distinct.
    function automatic logic [IW-1:0] imem_word(input logic [AW-1:0] a);
        return 32'h8D10_0200 ^ {3'b000, a, 12'h000};
    endfunction

    // Instruction memory with fixed one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: requests push the predicted entry, deliveries pop and compare.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_pc = '0;
        end else if (!clk) begin
            if (redirect_valid) begin
                exp_q.delete();
                exp_pc = {redirect_pc[AW-1:2], 2'b00};
            end else begin
                if (imem_req) begin
                    check("imem_addr", 32'(imem_addr), 32'(exp_pc));
                    exp_q.push_back('{pc: exp_pc, instr: imem_word(exp_pc)});
                    exp_pc = exp_pc + AW'(4);
                end
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_instr_pc", 32'(instr_pc), 32'hFFFF_FFFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("deliv_pc", 32'(instr_pc), 32'(mon_e.pc));
                        check("deliv_instr", instr, mon_e.instr);
                        n_deliv++;
                        last_pc = instr_pc;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic expect_first_req(input string tag, input logic [AW-1:0] addr);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (imem_req) begin
                seen = 1'b1;
                check(tag, 32'(imem_addr), 32'(addr));
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic expect_first_valid(input string tag, input logic [AW-1:0] pc);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                seen = 1'b1;
                check(tag, 32'(instr_pc), 32'(pc));
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_req;
        int first_val;
        int n_req;
        int n_moved;
        int d0;
        int k;
        bit found;
        bit prev_req;
        logic [AW-1:0] a0, a1, a2;

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_imem_req",    32'(imem_req),    32'd0);
        check("rst_imem_addr",   32'(imem_addr),   32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr",       instr,            32'd0);
        check("rst_instr_pc",    32'(instr_pc),    32'd0);
        check("rst_occupancy",   32'(occupancy),   32'd0);

        // Streaming and first-instruction latency
        step();
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        first_req = -1; first_val = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (imem_req && first_req < 0) first_req = c;
            if (instr_valid && first_val < 0) begin
                first_val = c;
                check("t1_first_pc",    32'(instr_pc), 32'd0);
                check("t1_first_instr", instr,         32'h8D10_0200);
            end
        end
        check("t1_latency", 32'(first_val - first_req), 32'd2);

        // Back-pressure: credit limits outstanding work to DEPTH
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        n_req = 0; n_moved = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req) n_req++;
            if (instr_valid && instr_pc != '0) n_moved++;
        end
        check("t2_req_count",  32'(n_req),       32'd4);
        check("t2_occupancy",  32'(occupancy),   32'd4);
        check("t2_head_valid", 32'(instr_valid), 32'd1);
        check("t2_head_pc",    32'(instr_pc),    32'd0);
        check("t2_head_instr", instr,            imem_word('0));
        check("t2_head_moved", 32'(n_moved),     32'd0);
        step();
        fetch_en = 1'b0; instr_ready = 1'b1;
        d0 = n_deliv;
        repeat (8) @(negedge clk);
        check("t2_delivered", 32'(n_deliv - d0), 32'd4);
        check("t2_last_pc",   32'(last_pc),      32'd12);
        check("t2_drained",   32'(occupancy),    32'd0);

        // Redirect with 3 buffered and 1 in flight
        do_reset();
        fetch_en = 1'b1; instr_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (occupancy == 3'd2 && imem_req) found = 1'b1;
        end
        check("t3_setup", 32'(found), 32'd1);
        step();
        redirect_valid = 1'b1; redirect_pc = 17'h000F6;
        @(negedge clk);
        check("t3_pre_occ", 32'(occupancy), 32'd3);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_flush_occ", 32'(occupancy), 32'd0);
        check("t3_flush_req", 32'(imem_req),  32'd0);
        @(negedge clk);
        check("t3_next_req",  32'(imem_req),  32'd1);
        check("t3_next_addr", 32'(imem_addr), 32'h0F4);
        step();
        instr_ready = 1'b1;
        expect_first_valid("t3_first_pc", 17'h000F4);

        // pc wrap at the top of the address space
        step();
        redirect_valid = 1'b1; redirect_pc = 17'h1FFF8;
        step();
        redirect_valid = 1'b0;
        k = 0; a0 = '0; a1 = '0; a2 = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req) begin
                if (k == 0) a0 = imem_addr;
                else if (k == 1) a1 = imem_addr;
                else if (k == 2) a2 = imem_addr;
                k++;
            end
        end
        check("t4_addr0", 32'(a0), 32'h1FFF8);
        check("t4_addr1", 32'(a1), 32'h1FFFC);
        check("t4_addr2", 32'(a2), 32'h00000);

        // Redirect coinciding with a pop and a push
        repeat (3) @(negedge clk);
        @(negedge clk);
        prev_req = imem_req;
        step();
        redirect_valid = 1'b1; redirect_pc = 17'h00200;
        @(negedge clk);
        check("t5_push_pending", 32'(prev_req),    32'd1);
        check("t5_pop_pending",  32'(instr_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_occ_after", 32'(occupancy), 32'd0);
        expect_first_valid("t5_first_pc", 17'h00200);

        // Asynchronous reset mid-stream with 2 entries buffered
        step();
        instr_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (occupancy == 3'd2) found = 1'b1;
        end
        check("t6_setup", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(instr_valid), 32'd0);
        check("t6_async_occ",   32'(occupancy),   32'd0);
        check("t6_async_req",   32'(imem_req),    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        expect_first_req("t6_restart_addr", '0);
        expect_first_valid("t6_first_pc", '0);
        repeat (10) @(negedge clk);

        // Drain and confirm nothing was lost
        step();
        fetch_en = 1'b0;
        repeat (10) @(negedge clk);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_occupancy",   32'(occupancy),    32'd0);
        check("end_valid",       32'(instr_valid),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
